// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// oversample divider calculation.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned div_calc(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clock pulse every DIV clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned OVS      = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV   = div_calc(CLK_FREQ, BAUD, OVS);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_chk
        $error("uart_baud_tick: CLK_FREQ too low for BAUD*OVS");
    end

    logic [CNT_W-1:0] cnt_q;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= wrap;
            cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with registered payload/status and a
// valid/ready hold stage that flags overrun when a frame is dropped.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned OVS         = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 2,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun_error,
    output logic                 rx_busy
);

    localparam int unsigned TICK_W = $clog2(OVS);
    localparam int unsigned BIT_W  = 4;

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 tick;
    logic [2:0]           state_q, state_nxt;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_nxt;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic                 parity_err_int, parity_err_nxt;
    logic                 frame_err_int, frame_err_nxt;
    logic                 frame_done, done_nxt;
    logic                 par_exp;
    logic                 sample_mid, sample_full;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer, idles high so reset cannot fake a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx_data};
    end
    assign rx_s = sync_q[1];

    assign par_exp     = (PARITY_MODE == PARITY_EVEN) ? ^shift_q : ~^shift_q;
    assign sample_mid  = tick && (tick_cnt_q == TICK_W'(OVS / 2 - 1));
    assign sample_full = tick && (tick_cnt_q == TICK_W'(OVS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tick_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            parity_err_int <= 1'b0;
            frame_err_int  <= 1'b0;
            frame_done     <= 1'b0;
            rx_busy        <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            tick_cnt_q     <= tick_cnt_nxt;
            bit_cnt_q      <= bit_cnt_nxt;
            shift_q        <= shift_nxt;
            parity_err_int <= parity_err_nxt;
            frame_err_int  <= frame_err_nxt;
            frame_done     <= done_nxt;
            rx_busy        <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt      = state_q;
        tick_cnt_nxt   = tick_cnt_q;
        bit_cnt_nxt    = bit_cnt_q;
        shift_nxt      = shift_q;
        parity_err_nxt = parity_err_int;
        frame_err_nxt  = frame_err_int;
        done_nxt       = 1'b0;
        if (tick && state_q != ST_IDLE) tick_cnt_nxt = tick_cnt_q + TICK_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt      = ST_START;
                    tick_cnt_nxt   = '0;
                    bit_cnt_nxt    = '0;
                    parity_err_nxt = 1'b0;
                    frame_err_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (sample_mid) begin
                    tick_cnt_nxt = '0;
                    state_nxt    = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_full) begin
                    tick_cnt_nxt = '0;
                    shift_nxt    = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (sample_full) begin
                    tick_cnt_nxt = '0;
                    if (rx_s != par_exp) parity_err_nxt = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_full) begin
                    tick_cnt_nxt = '0;
                    if (!rx_s) frame_err_nxt = 1'b1;
                    // Return to IDLE on the last sample so a back-to-back start is seen.
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_IDLE;
                        done_nxt    = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output hold stage: a completed frame is dropped if the previous one is unaccepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else if (frame_done) begin
            if (!rx_valid || rx_ready) begin
                rx_byte      <= shift_q;
                parity_error <= parity_err_int;
                frame_error  <= frame_err_int;
                rx_valid     <= 1'b1;
            end else begin
                overrun_error <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid      <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench: three receivers (8O1, 8E1, 8N2) at 32 clocks per bit.
module tb_uart_rx_ovs;

    localparam int unsigned CLK_FREQ = 3_200_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned OVS      = 16;
    localparam int CLK_PER_BIT       = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       line  [3];
    logic       ready [3];
    logic [7:0] rb    [3];
    logic       vld   [3];
    logic       pe    [3];
    logic       fe    [3];
    logic       oe    [3];
    logic       bsy   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_ovs #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS), .DATA_BITS(8),
                  .PARITY_MODE(2), .STOP_BITS(1)) dut_o1 (
        .clk(clk), .reset(reset), .rx_data(line[0]), .rx_byte(rb[0]),
        .rx_valid(vld[0]), .rx_ready(ready[0]), .parity_error(pe[0]),
        .frame_error(fe[0]), .overrun_error(oe[0]), .rx_busy(bsy[0]));

    uart_rx_ovs #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS), .DATA_BITS(8),
                  .PARITY_MODE(1), .STOP_BITS(1)) dut_e1 (
        .clk(clk), .reset(reset), .rx_data(line[1]), .rx_byte(rb[1]),
        .rx_valid(vld[1]), .rx_ready(ready[1]), .parity_error(pe[1]),
        .frame_error(fe[1]), .overrun_error(oe[1]), .rx_busy(bsy[1]));

    uart_rx_ovs #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(2)) dut_n2 (
        .clk(clk), .reset(reset), .rx_data(line[2]), .rx_byte(rb[2]),
        .rx_valid(vld[2]), .rx_ready(ready[2]), .parity_error(pe[2]),
        .frame_error(fe[2]), .overrun_error(oe[2]), .rx_busy(bsy[2]));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int sel, input logic v);
        line[sel] = v;
        repeat (CLK_PER_BIT) @(posedge clk);
    endtask

    // Drives a frame and returns 12 clocks into the last stop bit.
    task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                              input logic par, input logic s1, input logic s2, input int nstop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
        if (has_par) drive_bit(sel, par);
        if (nstop == 2) begin
            drive_bit(sel, s1);
            line[sel] = s2;
        end else begin
            line[sel] = s1;
        end
        repeat (12) @(posedge clk);
    endtask

    task automatic wait_valid(input int sel, output logic got);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (vld[sel] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 3; i++) line[i] = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        int   seen;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            line[i]  = 1'b1;
            ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("rst_byte",    16'(rb[0]), 16'h00);
        check("rst_valid",   16'(vld[0]), 16'h0);
        check("rst_perr",    16'(pe[0]), 16'h0);
        check("rst_ferr",    16'(fe[0]), 16'h0);
        check("rst_oerr",    16'(oe[0]), 16'h0);
        check("rst_busy",    16'(bsy[0]), 16'h0);
        reset = 1'b0;
        idle(10);

        // 8O1 0xA5, odd parity bit 1
        send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        wait_valid(0, got);
        check("a5_seen",  16'(got), 16'h1);
        check("a5_byte",  16'(rb[0]), 16'hA5);
        check("a5_perr",  16'(pe[0]), 16'h0);
        check("a5_ferr",  16'(fe[0]), 16'h0);
        @(negedge clk);
        check("a5_pulse", 16'(vld[0]), 16'h0);
        check("a5_idle",  16'(bsy[0]), 16'h0);
        idle(64);

        // 8E1 0x3C with wrong parity bit 1
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        wait_valid(1, got);
        check("3c_seen", 16'(got), 16'h1);
        check("3c_byte", 16'(rb[1]), 16'h3C);
        check("3c_perr", 16'(pe[1]), 16'h1);
        check("3c_ferr", 16'(fe[1]), 16'h0);
        idle(64);

        // 8N2 0x55 with second stop low, then clean 0x0F
        send_frame(2, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        wait_valid(2, got);
        line[2] = 1'b1;
        check("55_seen", 16'(got), 16'h1);
        check("55_byte", 16'(rb[2]), 16'h55);
        check("55_ferr", 16'(fe[2]), 16'h1);
        check("55_perr", 16'(pe[2]), 16'h0);
        idle(96);
        send_frame(2, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        wait_valid(2, got);
        check("0f_seen", 16'(got), 16'h1);
        check("0f_byte", 16'(rb[2]), 16'h0F);
        check("0f_ferr", 16'(fe[2]), 16'h0);
        idle(64);

        // 6-clock glitch on the 8O1 line
        line[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("gl_busy", 16'(bsy[0]), 16'h1);
        line[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (vld[0] === 1'b1) seen++;
        end
        check("gl_novalid", 16'(seen), 16'h0);
        check("gl_idle",    16'(bsy[0]), 16'h0);
        send_frame(0, 8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        wait_valid(0, got);
        check("81_seen", 16'(got), 16'h1);
        check("81_byte", 16'(rb[0]), 16'h81);
        check("81_perr", 16'(pe[0]), 16'h0);
        idle(64);

        // Overrun: 0x11 held, 0x22 dropped
        ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        wait_valid(0, got);
        check("11_seen", 16'(got), 16'h1);
        check("11_byte", 16'(rb[0]), 16'h11);
        check("11_oerr", 16'(oe[0]), 16'h0);
        idle(64);
        send_frame(0, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        idle(40);
        check("ov_valid", 16'(vld[0]), 16'h1);
        check("ov_byte",  16'(rb[0]), 16'h11);
        check("ov_oerr",  16'(oe[0]), 16'h1);
        ready[0] = 1'b1;
        @(negedge clk);
        ready[0] = 1'b0;
        check("hs_valid", 16'(vld[0]), 16'h0);
        check("hs_oerr",  16'(oe[0]), 16'h0);
        ready[0] = 1'b1;
        idle(64);

        // Reset during data bit 4 of 0xF0, then 0x7E
        line[0] = 1'b0;
        repeat (CLK_PER_BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
        line[0] = 1'b1;
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mr_byte",  16'(rb[0]), 16'h00);
        check("mr_valid", 16'(vld[0]), 16'h0);
        check("mr_busy",  16'(bsy[0]), 16'h0);
        check("mr_oerr",  16'(oe[0]), 16'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vld[0] === 1'b1) seen++;
        end
        check("mr_nopulse", 16'(seen), 16'h0);
        send_frame(0, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        wait_valid(0, got);
        check("7e_seen", 16'(got), 16'h1);
        check("7e_byte", 16'(rb[0]), 16'h7E);
        check("7e_perr", 16'(pe[0]), 16'h0);
        check("7e_ferr", 16'(fe[0]), 16'h0);
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
